// File: rtl/ariane_pkg.sv
// Shared types for the branch target buffer: resolved-branch update, fetch
// prediction, table entry layout and the saturating-counter helper.
// Build option: ARIANE_BTB_TAG_EN adds a stored tag to every table entry.
package ariane_pkg;

   localparam int unsigned BTB_ENTRIES             = 64;
   localparam int unsigned BITS_SATURATION_COUNTER = 2;
   // Widest tag possible (two-entry table); narrower tags are zero-extended.
   localparam int unsigned BTB_TAG_MAX_W           = 62;

   typedef logic [BITS_SATURATION_COUNTER-1:0] btb_cnt_t;

   // Resolved branch reported by the EX stage.
   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [63:0] target_address;
      logic        is_mispredict;
      logic        is_taken;
      logic        is_lower_16;
      logic        clear;
   } branchpredict_t;

   // Prediction handed to fetch.
   typedef struct packed {
      logic        valid;
      logic        predict_taken;
      logic [63:0] predict_address;
      logic        is_lower_16;
   } branchpredict_sbe_t;

   typedef struct packed {
      logic                     valid;
`ifdef ARIANE_BTB_TAG_EN
      logic [BTB_TAG_MAX_W-1:0] tag;
`endif
      logic [63:0]              target;
      logic                     is_lower_16;
      btb_cnt_t                 counter;
   } btb_entry_t;

   // Next value of a taken counter: count up on taken, down otherwise,
   // holding at all-ones and at zero.
   function automatic btb_cnt_t sat_cnt_next(input btb_cnt_t cnt, input logic taken);
      if (taken)
         return (&cnt) ? cnt : cnt + btb_cnt_t'(1);
      else
         return (cnt == '0) ? cnt : cnt - btb_cnt_t'(1);
   endfunction

endpackage

// File: rtl/btb.sv
// Branch target buffer: direct-mapped table indexed by pc[IDX_W:1],
// combinational lookup of registered state, one update per cycle from EX.
// Build option: ARIANE_BTB_TAG_EN stores and compares tags; without it
// aliasing PCs share an entry and a hit is just the valid bit.
module btb
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES              = ariane_pkg::BTB_ENTRIES,
   parameter int unsigned BITS_SATURATION_COUNTER = ariane_pkg::BITS_SATURATION_COUNTER
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic [63:0]        vpc_i,
   input  branchpredict_t     branchpredict_i,
   output branchpredict_sbe_t branch_predict_o
);

   localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

   typedef logic [IDX_W-1:0] idx_t;

   localparam logic [BITS_SATURATION_COUNTER-1:0] CNT_WEAK_TAKEN =
      {1'b1, {(BITS_SATURATION_COUNTER-1){1'b0}}};
   localparam logic [BITS_SATURATION_COUNTER-1:0] CNT_WEAK_NOT_TAKEN =
      {1'b0, {(BITS_SATURATION_COUNTER-1){1'b1}}};

   btb_entry_t btb_q [NR_ENTRIES];

   idx_t       look_idx;
   idx_t       upd_idx;
   btb_entry_t look_entry;
   btb_entry_t upd_cur;
   btb_entry_t upd_entry;
   logic       look_hit;
   logic       upd_hit;

   assign look_idx   = idx_t'(vpc_i >> 1);
   assign upd_idx    = idx_t'(branchpredict_i.pc >> 1);
   assign look_entry = btb_q[look_idx];
   assign upd_cur    = btb_q[upd_idx];

`ifdef ARIANE_BTB_TAG_EN
   function automatic logic [BTB_TAG_MAX_W-1:0] tag_of(input logic [63:0] pc);
      return BTB_TAG_MAX_W'(pc >> (IDX_W + 1));
   endfunction

   assign look_hit = look_entry.valid && (look_entry.tag == tag_of(vpc_i));
   assign upd_hit  = upd_cur.valid && (upd_cur.tag == tag_of(branchpredict_i.pc));
`else
   assign look_hit = look_entry.valid;
   assign upd_hit  = upd_cur.valid;
`endif

   // Bits that carry no information for this table configuration.
   logic unused_bits;
   assign unused_bits = ^{vpc_i[0], branchpredict_i.pc[0], branchpredict_i.is_mispredict
`ifndef ARIANE_BTB_TAG_EN
                          , vpc_i[63:IDX_W+1], branchpredict_i.pc[63:IDX_W+1]
`endif
                         };

   // Prediction from the registered table; all fields forced to zero on a miss.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      branch_predict_o = '0;
      if (look_hit) begin
         branch_predict_o.valid           = 1'b1;
         branch_predict_o.predict_taken   = look_entry.counter[BITS_SATURATION_COUNTER-1];
         branch_predict_o.predict_address = look_entry.target;
         branch_predict_o.is_lower_16     = look_entry.is_lower_16;
      end
   end

   // New contents for the indexed entry: allocate on a miss, train on a hit.
   always_comb begin
      upd_entry = upd_cur;
      if (!upd_hit) begin
         upd_entry.valid       = 1'b1;
`ifdef ARIANE_BTB_TAG_EN
         upd_entry.tag         = tag_of(branchpredict_i.pc);
`endif
         upd_entry.target      = branchpredict_i.target_address;
         upd_entry.is_lower_16 = branchpredict_i.is_lower_16;
         upd_entry.counter     = branchpredict_i.is_taken ? CNT_WEAK_TAKEN : CNT_WEAK_NOT_TAKEN;
      end else begin
         upd_entry.counter = sat_cnt_next(upd_cur.counter, branchpredict_i.is_taken);
         if (branchpredict_i.is_taken) begin
            upd_entry.target      = branchpredict_i.target_address;
            upd_entry.is_lower_16 = branchpredict_i.is_lower_16;
         end
      end
   end

   // Table state: reset, flush (wins over update), then clear or write-back.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the table is a register array, not a RAM macro, so it can and
         // must be cleared by reset; every field goes to zero.
         for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            btb_q[i] <= '0;
         end
      end else if (flush_i) begin
         for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            btb_q[i].valid <= 1'b0;
         end
      end else if (branchpredict_i.valid) begin
         // NOTE: non-blocking writes keep the same-cycle lookup on the old
         // contents; a blocking write here would create a hidden bypass.
         if (branchpredict_i.clear) begin
            btb_q[upd_idx].valid <= 1'b0;
         end else begin
            btb_q[upd_idx] <= upd_entry;
         end
      end
   end

endmodule

// File: tb/tb_btb.sv
// Directed scoreboard bench for btb: stimulus pushes expected predictions,
// a negedge monitor pops and compares while a lookup is being presented.
// Expectations for the aliasing lookup follow ARIANE_BTB_TAG_EN.
module tb_btb;
   import ariane_pkg::*;

   logic               clk_i;
   logic               rst_ni;
   logic               flush_i;
   logic [63:0]        vpc_i;
   branchpredict_t     branchpredict_i;
   branchpredict_sbe_t branch_predict_o;

   logic               look_req;

   typedef struct {
      string              name;
      branchpredict_sbe_t exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_vec;
   int  n_err;

   btb dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .vpc_i            (vpc_i),
      .branchpredict_i  (branchpredict_i),
      .branch_predict_o (branch_predict_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Queue an expectation for the lookup presented this cycle.
   task automatic expect_lookup(input logic [63:0] pc, input logic v, input logic t,
                                input logic [63:0] addr, input logic l16, input string name);
      sb_t e;
      e.name                = name;
      e.exp                 = '0;
      e.exp.valid           = v;
      e.exp.predict_taken   = v & t;
      e.exp.predict_address = v ? addr : 64'h0;
      e.exp.is_lower_16     = v & l16;
      vpc_i    = pc;
      look_req = 1'b1;
      sb_q.push_back(e);
   endtask

   task automatic lookup(input logic [63:0] pc, input logic v, input logic t,
                         input logic [63:0] addr, input logic l16, input string name);
      expect_lookup(pc, v, t, addr, l16, name);
      tick();
      look_req = 1'b0;
   endtask

   task automatic set_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                             input logic l16, input logic clr);
      branchpredict_i                = '0;
      branchpredict_i.valid          = 1'b1;
      branchpredict_i.pc             = pc;
      branchpredict_i.target_address = tgt;
      branchpredict_i.is_mispredict  = 1'b1;
      branchpredict_i.is_taken       = taken;
      branchpredict_i.is_lower_16    = l16;
      branchpredict_i.clear          = clr;
   endtask

   task automatic update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                         input logic l16, input logic clr);
      set_update(pc, tgt, taken, l16, clr);
      tick();
      branchpredict_i = '0;
   endtask

   // Monitor: compare the presented prediction against the queue head.
   initial begin
      forever begin
         @(negedge clk_i);
         if (look_req) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_lookup: got valid=%0b with empty scoreboard",
                        branch_predict_o.valid);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               if (branch_predict_o !== e.exp) begin
                  n_err++;
                  $display("FAIL %s: got v=%0b t=%0b addr=%h l16=%0b, expected v=%0b t=%0b addr=%h l16=%0b",
                           e.name, branch_predict_o.valid, branch_predict_o.predict_taken,
                           branch_predict_o.predict_address, branch_predict_o.is_lower_16,
                           e.exp.valid, e.exp.predict_taken, e.exp.predict_address,
                           e.exp.is_lower_16);
               end
            end
         end
      end
   end

   initial begin
      n_vec           = 0;
      n_err           = 0;
      rst_ni          = 1'b0;
      flush_i         = 1'b0;
      vpc_i           = '0;
      branchpredict_i = '0;
      look_req        = 1'b0;
      tick();

      // Update presented while reset is held is discarded; output stays zero.
      set_update(64'h1000, 64'h2000, 1'b1, 1'b0, 1'b0);
      lookup(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, "in_reset");
      branchpredict_i = '0;
      rst_ni          = 1'b1;

      lookup(64'h80,   1'b0, 1'b0, 64'h0, 1'b0, "reset_0x80");
      lookup(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, "reset_update_dropped");

      // Allocate taken: weakly taken.
      update(64'h1000, 64'h2000, 1'b1, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0, "alloc_taken");

      // Not-taken update with same-cycle lookup sees pre-update contents.
      set_update(64'h1000, 64'h2222, 1'b0, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0, "same_cycle_old");
      branchpredict_i = '0;
      lookup(64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0, "cnt_01");
      update(64'h1000, 64'h2222, 1'b0, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0, "cnt_00");
      update(64'h1000, 64'h2222, 1'b0, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0, "cnt_sat_low");
      update(64'h1000, 64'h2100, 1'b1, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b0, 64'h2100, 1'b0, "cnt_up_01_tgt");
      update(64'h1000, 64'h2400, 1'b1, 1'b1, 1'b0);
      lookup(64'h1000, 1'b1, 1'b1, 64'h2400, 1'b1, "cnt_10_l16");
      update(64'h1000, 64'h2400, 1'b1, 1'b1, 1'b0);
      update(64'h1000, 64'h2400, 1'b1, 1'b1, 1'b0);
      update(64'h1000, 64'h2222, 1'b0, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b1, 64'h2400, 1'b1, "cnt_sat_high");

      // Same index, different tag.
`ifdef ARIANE_BTB_TAG_EN
      lookup(64'h1080, 1'b0, 1'b0, 64'h0, 1'b0, "alias_tagged");
`else
      lookup(64'h1080, 1'b1, 1'b1, 64'h2400, 1'b1, "alias_shared");
`endif

      // Allocate not-taken in a second entry: weakly not-taken.
      update(64'h3004, 64'h5000, 1'b0, 1'b0, 1'b0);
      lookup(64'h3004, 1'b1, 1'b0, 64'h5000, 1'b0, "alloc_not_taken");

      // Clear touches only the indexed entry.
      update(64'h1000, 64'h0, 1'b0, 1'b0, 1'b1);
      lookup(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, "clear_entry");
      lookup(64'h3004, 1'b1, 1'b0, 64'h5000, 1'b0, "clear_other_kept");

      // Flush beats a same-cycle taken update.
      update(64'h1000, 64'h2000, 1'b1, 1'b0, 1'b0);
      lookup(64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0, "realloc");
      flush_i = 1'b1;
      update(64'h3000, 64'h7000, 1'b1, 1'b0, 1'b0);
      flush_i = 1'b0;
      lookup(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, "flush_0x1000");
      lookup(64'h3000, 1'b0, 1'b0, 64'h0, 1'b0, "flush_0x3000");
      lookup(64'h3004, 1'b0, 1'b0, 64'h0, 1'b0, "flush_0x3004");

      // Not-taken allocation still writes target and size.
      update(64'h1000, 64'h6000, 1'b0, 1'b1, 1'b0);
      lookup(64'h1000, 1'b1, 1'b0, 64'h6000, 1'b1, "alloc_nt_tgt");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btb.md
BTB -- requirements
Module: btb

Interface
REQ-001 Parameter NR_ENTRIES, default BTB_ENTRIES (64), is the number of table entries and SHALL be a power of two ≥ 2.
REQ-002 Parameter BITS_SATURATION_COUNTER, default BITS_SATURATION_COUNTER (2), is the width of each entry's taken counter.
REQ-003 clk_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  is the reset: asynchronous, active-low.
REQ-005 flush_i  input  1  invalidates the whole table.
REQ-006 vpc_i  input  64  is the fetch PC to look up.
REQ-007 branchpredict_i  input  branchpredict  is the resolved-branch update from the EX stage.
REQ-008 branch_predict_o  output  branchpredict_sbe  is the prediction for vpc_i, consumed by fetch.

Function
REQ-009 Index SHALL be pc[$clog2(NR_ENTRIES):1], with bit 0 ignored; tag SHALL be pc[63:$clog2(NR_ENTRIES)+1].
REQ-010 Each entry SHALL hold: valid, tag, target[63:0], is_lower_16, and counter[BITS_SATURATION_COUNTER-1:0].
REQ-011 Lookup SHALL be combinational with zero-cycle latency and SHALL read only registered table state (no update-to-lookup bypass).
REQ-012 branch_predict_o.valid SHALL be entry.valid AND tag match.
REQ-013 branch_predict_o.predict_taken SHALL be counter MSB AND valid.
REQ-014 predict_address and is_lower_16 SHALL come from the entry; all output fields SHALL be 0 when valid is 0.
REQ-015 An update with branchpredict_i.valid=1 and clear=1 SHALL clear the valid bit of the indexed entry only.
REQ-016 An update with valid=1, clear=0 that misses (invalid or tag mismatch) SHALL allocate the entry: valid=1, new tag, target=target_address, is_lower_16, counter = weakly taken (MSB=1, rest 0) if is_taken, else weakly not-taken (MSB=0, rest 1).
REQ-017 An update with valid=1, clear=0 that hits SHALL increment the counter if is_taken and decrement it otherwise, saturating at all-ones and 0.
- On a hit, target and is_lower_16 SHALL be rewritten only when is_taken=1.
REQ-018 Updates SHALL become visible to lookup the cycle after they are presented.
REQ-019 If flush_i and an update occur in the same cycle, flush wins: every entry is invalid next cycle.
REQ-020 If lookup and update hit the same index in the same cycle, lookup SHALL return pre-update contents.

Reset
REQ-021 rst_ni low SHALL asynchronously clear every entry's valid, tag, target, is_lower_16 and counter to 0, so branch_predict_o is all-zero.
REQ-022 Reset asserted mid-update SHALL discard the update; no partial entry SHALL survive.

Configuration
REQ-023 With macro ARIANE_BTB_TAG_EN defined, tags SHALL be stored and compared per REQ-012.
REQ-024 With ARIANE_BTB_TAG_EN undefined, no tag storage SHALL exist, hit SHALL equal entry.valid, and aliasing PCs SHALL share entries.

Structure
REQ-025 ariane_pkg SHALL gain typedef btb_entry_t (fields per REQ-010).
- BTB_ENTRIES and BITS_SATURATION_COUNTER SHALL stay in ariane_pkg.
- The saturating-counter next-value SHALL be a package function.
REQ-026 No sub-module is warranted; btb SHALL be a single flat module.

Verification (NR_ENTRIES=64, 2-bit counter)
REQ-027 Reset, then vpc_i=0x80 -> branch_predict_o all-zero.
REQ-028 Update pc=0x1000, target 0x2000, is_taken=1, is_mispredict=1 -> next cycle vpc_i=0x1000 gives valid=1, predict_taken=1, predict_address=0x2000, counter=2'b10.
REQ-029 Then three not-taken updates at 0x1000 -> counter 10→01→00→00 (saturates), predict_taken=0, valid=1, predict_address still 0x2000.
REQ-030 After REQ-028, vpc_i=0x1080 (same index 0, different tag) -> valid=0 with ARIANE_BTB_TAG_EN; valid=1, address 0x2000 without it.
REQ-031 flush_i=1 in the same cycle as a taken update at 0x3000 -> next cycle lookups of 0x1000 and 0x3000 both give valid=0.
REQ-032 Update pc=0x1000, clear=1 -> next cycle lookup 0x1000 gives valid=0, and other entries are unchanged.
